uart_rx_fifo: RTL and testbench

//   Parametrised oversampling UART receiver with a buffered output FIFO.
//   It replaces the fixed 8N1 receive path in front of the matrix input/calc selector.

---
 rtl/uart_rx_fifo.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver (majority-vote sampling, parity/framing checks, sticky error flags)
// feeding a first-word-fall-through FIFO.
module uart_rx_fifo #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          uart_rx,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overflow,
  input  logic                          err_clr
);
  localparam int unsigned TickDen = BAUD_RATE * OVERSAMPLE;
  localparam int unsigned Div     = (CLK_FREQ + TickDen / 2) / TickDen;
  localparam int unsigned DivW    = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned SW      = $clog2(OVERSAMPLE);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CW      = AW + 1;
  localparam int unsigned Mid     = OVERSAMPLE / 2;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

  state_e                 state_q;
  logic                   rx_meta_q, rx_sync_q, rx_prev_q;
  logic [DivW-1:0]        div_cnt_q;
  logic [SW-1:0]          tick_cnt_q, hi_cnt_q;
  logic                   s0_q, s1_q;
  logic [3:0]             bit_cnt_q;
  logic [DATA_BITS-1:0]   data_q;
  logic                   bad_q, push_q, ferr_set_q, perr_set_q;
  logic                   tick, vote_now, vote;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign tick     = (state_q != StIdle) && (div_cnt_q == DivW'(Div - 1));
  assign vote_now = tick && (tick_cnt_q == SW'(Mid + 1));
  assign vote     = (s0_q & s1_q) | (s0_q & rx_sync_q) | (s1_q & rx_sync_q);

  // Tick phase is held at zero while idle so the first bit is sampled relative to the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      tick_cnt_q <= '0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
    end else if (state_q == StIdle) begin
      div_cnt_q  <= '0;
      tick_cnt_q <= '0;
    end else begin
      div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;
      if (tick) begin
        tick_cnt_q <= (tick_cnt_q == SW'(OVERSAMPLE - 1)) ? '0 : tick_cnt_q + 1'b1;
        if (tick_cnt_q == SW'(Mid - 1)) s0_q <= rx_sync_q;
        if (tick_cnt_q == SW'(Mid))     s1_q <= rx_sync_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      hi_cnt_q   <= '0;
      data_q     <= '0;
      bad_q      <= 1'b0;
      push_q     <= 1'b0;
      ferr_set_q <= 1'b0;
      perr_set_q <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      ferr_set_q <= 1'b0;
      perr_set_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rx_prev_q && !rx_sync_q) begin
            state_q   <= StStart;
            bad_q     <= 1'b0;
            bit_cnt_q <= '0;
          end
        end
        StStart: begin
          if (vote_now) state_q <= vote ? StIdle : StData;
        end
        StData: begin
          if (vote_now) begin
            data_q <= {vote, data_q[DATA_BITS-1:1]};
            if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
              bit_cnt_q <= '0;
              state_q   <= (PARITY != 0) ? StParity : StStop;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        StParity: begin
          if (vote_now) begin
            if ((^data_q ^ vote) != (PARITY == 1)) begin
              perr_set_q <= 1'b1;
              bad_q      <= 1'b1;
            end
            state_q <= StStop;
          end
        end
        StStop: begin
          if (vote_now) begin
            if (!vote) begin
              ferr_set_q <= 1'b1;
              bad_q      <= 1'b1;
              hi_cnt_q   <= '0;
              state_q    <= StBreak;
            end else if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
              push_q  <= !bad_q;
              state_q <= StIdle;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        StBreak: begin
          // Stay here until the line has been high for a whole bit of ticks.
          if (tick) begin
            if (!rx_sync_q)                           hi_cnt_q <= '0;
            else if (hi_cnt_q == SW'(OVERSAMPLE - 1)) state_q  <= StIdle;
            else                                      hi_cnt_q <= hi_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 full, pop, do_push;
  logic                 ferr_q, perr_q, ovf_q;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = rd_en && (count_q != '0);
  assign do_push = push_q && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !pop)      count_q <= count_q + 1'b1;
      else if (!do_push && pop) count_q <= count_q - 1'b1;
    end
  end

  // Set wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      ferr_q <= ferr_set_q | (ferr_q & ~err_clr);
      perr_q <= perr_set_q | (perr_q & ~err_clr);
      ovf_q  <= (push_q && full && !pop) | (ovf_q & ~err_clr);
    end
  end

  assign rd_valid   = (count_q != '0);
  assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count = count_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: three receiver instances (8N1/16-deep, 8E1, 8N1/4-deep) driven bit-banged.
module tb_uart_rx_fifo;
  localparam int BitClks = 160;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rx, rd_en, err_clr;
  logic [2:0] rd_valid, frame_err, parity_err, overflow;
  logic [7:0] rd_data0, rd_data1, rd_data2;
  logic [4:0] cnt0, cnt1;
  logic [2:0] cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx[0]), .rd_en(rd_en[0]), .rd_data(rd_data0),
    .rd_valid(rd_valid[0]), .fifo_count(cnt0), .frame_err(frame_err[0]),
    .parity_err(parity_err[0]), .overflow(overflow[0]), .err_clr(err_clr[0])
  );

  uart_rx_fifo #(.CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16), .PARITY(2)) u_par (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx[1]), .rd_en(rd_en[1]), .rd_data(rd_data1),
    .rd_valid(rd_valid[1]), .fifo_count(cnt1), .frame_err(frame_err[1]),
    .parity_err(parity_err[1]), .overflow(overflow[1]), .err_clr(err_clr[1])
  );

  uart_rx_fifo #(.CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16), .FIFO_DEPTH(4))
    u_d4 (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx[2]), .rd_en(rd_en[2]), .rd_data(rd_data2),
    .rd_valid(rd_valid[2]), .fifo_count(cnt2), .frame_err(frame_err[2]),
    .parity_err(parity_err[2]), .overflow(overflow[2]), .err_clr(err_clr[2])
  );

  function automatic logic [7:0] get_data(input int i);
    case (i)
      0:       return rd_data0;
      1:       return rd_data1;
      default: return rd_data2;
    endcase
  endfunction

  function automatic int get_count(input int i);
    case (i)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_bits(input int n);
    repeat (n * BitClks) @(negedge clk);
  endtask

  task automatic send_frame(input int i, input logic [7:0] d, input bit has_par,
                            input logic pbit, input int stop_low);
    rx[i] = 1'b0;
    wait_bits(1);
    for (int b = 0; b < 8; b++) begin
      rx[i] = d[b];
      wait_bits(1);
    end
    if (has_par) begin
      rx[i] = pbit;
      wait_bits(1);
    end
    if (stop_low > 0) begin
      rx[i] = 1'b0;
      wait_bits(stop_low);
    end
    rx[i] = 1'b1;
    wait_bits(2);
  endtask

  task automatic pop(input int i);
    @(negedge clk);
    rd_en[i] = 1'b1;
    @(negedge clk);
    rd_en[i] = 1'b0;
  endtask

  task automatic clear_flags(input int i);
    @(negedge clk);
    err_clr[i] = 1'b1;
    @(negedge clk);
    err_clr[i] = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    int         idx;
    logic [7:0] data;
    bit         has_par;
    logic       pbit;
    int         stop_low;
    int         exp_count;
    logic       exp_ferr;
    logic       exp_perr;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{0, 8'h5A, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{0, 8'hA5, 1'b0, 1'b0, 0, 2, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{0, 8'h3C, 1'b0, 1'b0, 3, 2, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{0, 8'h11, 1'b0, 1'b0, 0, 3, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1, 8'h07, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1, 8'h07, 1'b1, 1'b1, 0, 1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{2, 8'h01, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{2, 8'h02, 1'b0, 1'b0, 0, 2, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{2, 8'h03, 1'b0, 1'b0, 0, 3, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{2, 8'h04, 1'b0, 1'b0, 0, 4, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{2, 8'h05, 1'b0, 1'b0, 0, 4, 1'b0, 1'b0, 1'b1};

    rst_n   = 1'b0;
    rx      = 3'b111;
    rd_en   = 3'b000;
    err_clr = 3'b000;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_count[%0d]", i), get_count(i), 0);
      check($sformatf("reset_data[%0d]", i), get_data(i), 8'h00);
    end
    check("reset_valid", rd_valid, 3'b000);
    check("reset_flags", {frame_err, parity_err, overflow}, 9'h000);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Short low pulse must be rejected as a glitch.
    rx[0] = 1'b0;
    repeat (40) @(negedge clk);
    rx[0] = 1'b1;
    wait_bits(2);
    check("glitch_count", get_count(0), 0);
    check("glitch_flags", {frame_err[0], parity_err[0], overflow[0]}, 3'b000);

    for (int v = 0; v < 11; v++) begin
      send_frame(vecs[v].idx, vecs[v].data, vecs[v].has_par, vecs[v].pbit, vecs[v].stop_low);
      check($sformatf("vec%0d_count", v), get_count(vecs[v].idx), vecs[v].exp_count);
      check($sformatf("vec%0d_ferr", v), frame_err[vecs[v].idx], vecs[v].exp_ferr);
      check($sformatf("vec%0d_perr", v), parity_err[vecs[v].idx], vecs[v].exp_perr);
      check($sformatf("vec%0d_ovf", v), overflow[vecs[v].idx], vecs[v].exp_ovf);
    end

    check("8n1_head0", get_data(0), 8'h5A);
    pop(0);
    check("8n1_head1", get_data(0), 8'hA5);
    pop(0);
    check("8n1_head2", get_data(0), 8'h11);
    check("8n1_count_after_pops", get_count(0), 1);

    check("par_head", get_data(1), 8'h07);
    clear_flags(1);
    check("par_err_cleared", parity_err[1], 1'b0);
    check("par_count_kept", get_count(1), 1);

    for (int k = 0; k < 4; k++) begin
      check($sformatf("d4_read%0d", k), get_data(2), 8'(k + 1));
      pop(2);
    end
    check("d4_empty_valid", rd_valid[2], 1'b0);
    pop(2);
    check("d4_underflow_count", get_count(2), 0);
    check("d4_ovf_sticky", overflow[2], 1'b1);
    clear_flags(2);
    check("d4_ovf_cleared", overflow[2], 1'b0);

    // Reset in the middle of the data bits abandons the frame.
    fork
      send_frame(0, 8'hC3, 1'b0, 1'b0, 0);
      begin
        repeat (4 * BitClks) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_count", get_count(0), 0);
        check("midrst_valid", rd_valid[0], 1'b0);
        check("midrst_data", get_data(0), 8'h00);
        check("midrst_flags", {frame_err[0], parity_err[0], overflow[0]}, 3'b000);
      end
    join
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("postrst_count", get_count(0), 0);
    send_frame(0, 8'hC3, 1'b0, 1'b0, 0);
    check("postrst_rx_count", get_count(0), 1);
    check("postrst_rx_data", get_data(0), 8'hC3);
    check("postrst_flags", {frame_err[0], parity_err[0], overflow[0]}, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
